// File: rtl/uart_time_tx.sv
// rtl/uart_time_tx.sv - formats an hour/minute/second snapshot as "HH:MM:SS\r\n" and sends it 8N1 on a UART tx pin
module uart_time_tx #(
  parameter int TICKS_PER_BIT = 16,
  parameter bit SEND_CRLF     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       b_tick,
  input  logic       i_send,
  input  logic [4:0] i_hour,
  input  logic [5:0] i_min,
  input  logic [5:0] i_sec,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);

  localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
  localparam logic [3:0] LAST_BYTE = SEND_CRLF ? 4'd9 : 4'd7;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    bit_idx;
  logic [3:0]    byte_idx;
  logic [5:0]    snap_hour;
  logic [5:0]    snap_min;
  logic [5:0]    snap_sec;
  logic [7:0]    cur_byte;
  logic          bit_end;

  function automatic logic [7:0] tens_char(input logic [5:0] v);
    logic [5:0] q;
    q = v / 6'd10;
    return 8'h30 + {2'b00, q};
  endfunction

  function automatic logic [7:0] ones_char(input logic [5:0] v);
    logic [5:0] r;
    r = v % 6'd10;
    return 8'h30 + {2'b00, r};
  endfunction

  // Byte to send is derived from the snapshot each cycle; only o_tx is registered.
  always_comb begin
    cur_byte = 8'h00;
    case (byte_idx)
      4'd0:    cur_byte = tens_char(snap_hour);
      4'd1:    cur_byte = ones_char(snap_hour);
      4'd2:    cur_byte = 8'h3A;
      4'd3:    cur_byte = tens_char(snap_min);
      4'd4:    cur_byte = ones_char(snap_min);
      4'd5:    cur_byte = 8'h3A;
      4'd6:    cur_byte = tens_char(snap_sec);
      4'd7:    cur_byte = ones_char(snap_sec);
      4'd8:    cur_byte = 8'h0D;
      4'd9:    cur_byte = 8'h0A;
      default: cur_byte = 8'h00;
    endcase
  end

  assign bit_end = b_tick && (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      o_tx      <= 1'b1;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      snap_hour <= '0;
      snap_min  <= '0;
      snap_sec  <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_send) begin
            snap_hour <= {1'b0, i_hour};
            snap_min  <= i_min;
            snap_sec  <= i_sec;
            state     <= START;
            o_tx      <= 1'b0;
            o_busy    <= 1'b1;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            tick_cnt <= '0;
            bit_idx  <= '0;
            o_tx     <= cur_byte[0];
            state    <= DATA;
          end else if (b_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            tick_cnt <= '0;
            if (bit_idx == 3'd7) begin
              o_tx  <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              o_tx    <= cur_byte[bit_idx + 3'd1];
            end
          end else if (b_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            tick_cnt <= '0;
            // Next start bit follows the stop bit directly, no idle gap.
            if (byte_idx == LAST_BYTE) begin
              byte_idx <= '0;
              o_busy   <= 1'b0;
              o_done   <= 1'b1;
              state    <= IDLE;
            end else begin
              byte_idx <= byte_idx + 4'd1;
              o_tx     <= 1'b0;
              state    <= START;
            end
          end else if (b_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_time_tx.sv
// tb/tb_uart_time_tx.sv - randomized self-checking bench for uart_time_tx with a line-level UART model
module tb_uart_time_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       b_tick = 1'b0;
  logic       send10 = 1'b0;
  logic       send8 = 1'b0;
  logic [4:0] hour = '0;
  logic [5:0] min = '0;
  logic [5:0] sec = '0;
  logic       tx10, busy10, done10;
  logic       tx8, busy8, done8;

  int checks = 0;
  int errors = 0;
  int tick_total = 0;
  int bt10 = 0, bt8 = 0, dc10 = 0, dc8 = 0;
  logic [7:0] exp_q[$];

  uart_time_tx #(.TICKS_PER_BIT(16), .SEND_CRLF(1'b1)) dut (
    .clk(clk), .rst(rst), .b_tick(b_tick), .i_send(send10),
    .i_hour(hour), .i_min(min), .i_sec(sec),
    .o_tx(tx10), .o_busy(busy10), .o_done(done10)
  );

  uart_time_tx #(.TICKS_PER_BIT(16), .SEND_CRLF(1'b0)) dut8 (
    .clk(clk), .rst(rst), .b_tick(b_tick), .i_send(send8),
    .i_hour(hour), .i_min(min), .i_sec(sec),
    .o_tx(tx8), .o_busy(busy8), .o_done(done8)
  );

  always #5 clk = ~clk;

  int ph;
  initial begin
    ph = 0;
    forever begin
      @(negedge clk);
      b_tick = (ph == 0);
      ph = (ph + 1) % 3;
    end
  end

  always @(posedge clk) begin
    if (b_tick) tick_total <= tick_total + 1;
    if (b_tick && busy10) bt10 <= bt10 + 1;
    if (b_tick && busy8) bt8 <= bt8 + 1;
    dc10 <= dc10 + (done10 ? 1 : 0);
    dc8 <= dc8 + (done8 ? 1 : 0);
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic txw(input int w);
    return (w != 0) ? tx8 : tx10;
  endfunction
  function automatic logic busyw(input int w);
    return (w != 0) ? busy8 : busy10;
  endfunction
  function automatic int btw(input int w);
    return (w != 0) ? bt8 : bt10;
  endfunction
  function automatic int dcw(input int w);
    return (w != 0) ? dc8 : dc10;
  endfunction

  // Expected line: two decimal digits per field, ':' separators, optional CR LF.
  task automatic model_line(input int h, input int m, input int s, input bit crlf);
    int v[3];
    v[0] = h; v[1] = m; v[2] = s;
    exp_q.delete();
    for (int f = 0; f < 3; f++) begin
      exp_q.push_back(8'(48 + v[f] / 10));
      exp_q.push_back(8'(48 + v[f] % 10));
      if (f < 2) exp_q.push_back(8'h3A);
    end
    if (crlf) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endtask

  task automatic wait_tick(input int target, output bit ok);
    int n;
    n = 0;
    ok = 1'b1;
    while (tick_total < target) begin
      @(negedge clk);
      n++;
      if (n > 1000) begin
        ok = 1'b0;
        return;
      end
    end
  endtask

  // Mid-bit sampling counted in b_ticks from the observed falling edge.
  task automatic rx_byte(input int w, output logic [7:0] d, output int ts);
    int n;
    bit ok, all_ok;
    logic sb, eb;
    d = '0;
    n = 0;
    all_ok = 1'b1;
    while (txw(w) !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    ts = tick_total;
    if (txw(w) !== 1'b0) begin
      check("rx_start_timeout", 32'd1, 32'd0);
      return;
    end
    wait_tick(ts + 8, ok); all_ok &= ok;
    sb = txw(w);
    for (int k = 0; k < 8; k++) begin
      wait_tick(ts + 24 + 16 * k, ok); all_ok &= ok;
      d[k] = txw(w);
    end
    wait_tick(ts + 152, ok); all_ok &= ok;
    eb = txw(w);
    check("frame", {29'd0, all_ok, sb, eb}, 32'h5);
  endtask

  task automatic run_line(input int w, input int h, input int m, input int s, input bit disturb);
    int n, d0, b0, ts, tprev, k;
    logic [7:0] d;
    hour = 5'(h); min = 6'(m); sec = 6'(s);
    model_line(h, m, s, w == 0);
    n = exp_q.size();
    d0 = dcw(w);
    b0 = btw(w);
    tprev = 0;
    if (w != 0) send8 = 1'b1; else send10 = 1'b1;
    @(negedge clk);
    send8 = 1'b0; send10 = 1'b0;
    check("accept", {30'd0, busyw(w), txw(w)}, 32'h2);
    for (int i = 0; i < n; i++) begin
      rx_byte(w, d, ts);
      check("byte", {24'd0, d}, {24'd0, exp_q[i]});
      if (i > 0) check("gap", ts - tprev, 160);
      tprev = ts;
      if (disturb && i == 2) begin
        hour = 5'd1; min = 6'd2; sec = 6'd3;
        send10 = 1'b1;
        @(negedge clk);
        send10 = 1'b0;
      end
    end
    k = 0;
    while (busyw(w) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("busy_end", {31'd0, busyw(w)}, 32'd0);
    @(negedge clk);
    check("busy_ticks", btw(w) - b0, n * 160);
    check("done_cnt", dcw(w) - d0, 1);
  endtask

  initial begin
    int ts, d0, b0, k, lows;
    logic [7:0] d;

    rst = 1'b0; send10 = 1'b1; send8 = 1'b1;
    hour = 5'd12; min = 6'd34; sec = 6'd56;
    repeat (5) @(negedge clk);
    check("rst_out10", {29'd0, tx10, busy10, done10}, 32'h4);
    check("rst_out8", {29'd0, tx8, busy8, done8}, 32'h4);
    send10 = 1'b0; send8 = 1'b0;
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_after_rst", {28'd0, tx10, busy10, tx8, busy8}, 32'hA);

    run_line(0, 12, 34, 56, 1'b0);
    run_line(0, 0, 0, 0, 1'b0);
    run_line(0, 31, 63, 63, 1'b0);

    run_line(0, 23, 59, 58, 1'b1);
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy10 || !tx10) lows++;
    end
    check("no_requeue", lows, 0);

    // Abort in byte 4, data bit 3.
    hour = 5'd20; min = 6'd45; sec = 6'd13;
    send10 = 1'b1;
    @(negedge clk);
    send10 = 1'b0;
    for (int i = 0; i < 4; i++) rx_byte(0, d, ts);
    k = 0;
    while (tx10 !== 1'b0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    ts = tick_total;
    k = 0;
    while (tick_total < ts + 72 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    d0 = dc10;
    rst = 1'b0;
    @(negedge clk);
    check("abort_out", {30'd0, tx10, busy10}, 32'h2);
    rst = 1'b1;
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy10 || !tx10) lows++;
    end
    check("abort_quiet", lows, 0);
    check("abort_no_done", dc10 - d0, 0);
    run_line(0, $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63), 1'b0);

    for (int r = 0; r < 3; r++)
      run_line(0, $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63), 1'b0);

    // Eight-byte variant with i_send held high: retrigger right after o_done.
    hour = 5'd7; min = 6'd8; sec = 6'd9;
    model_line(7, 8, 9, 1'b0);
    d0 = dc8; b0 = bt8;
    send8 = 1'b1;
    @(negedge clk);
    check("accept8", {30'd0, busy8, tx8}, 32'h2);
    for (int line = 0; line < 2; line++) begin
      for (int i = 0; i < 8; i++) begin
        rx_byte(1, d, ts);
        check("byte8", {24'd0, d}, {24'd0, exp_q[i]});
      end
      k = 0;
      while (!done8 && k < 300) begin
        @(negedge clk);
        k++;
      end
      check("done8_seen", {31'd0, done8}, 32'd1);
      check("busy_ticks8", bt8 - b0, 1280);
      @(negedge clk);
      check("done8_cnt", dc8 - d0, 1);
      if (line == 0) begin
        check("retrigger", {30'd0, busy8, tx8}, 32'h2);
        send8 = 1'b0;
        d0 = dc8; b0 = bt8;
      end else begin
        check("idle8", {30'd0, busy8, tx8}, 32'h1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_time_tx.md
Name: uart_time_tx

Overview:
- Formats a watch time snapshot (hour, minute, second) as the ASCII line "HH:MM:SS\r\n".
- Serialises that line on a UART tx pin, 8N1, LSB first.
- Sits on the transmit side of the watch UART path, in parallel with the echo path: the receive side decodes incoming bytes, and this block reports the current time back to the host.
- Shares the design's 16x oversampled baud tick.

Parameters:
- TICKS_PER_BIT, 16, number of b_tick pulses per UART bit period.
- SEND_CRLF, 1, 1 = append 0x0D 0x0A (10 bytes per line); 0 = 8 bytes, no terminator.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-low reset
- b_tick  input  1  one-clk pulse at 16x baud rate
- i_send  input  1  request to transmit one time line (level or pulse)
- i_hour  input  5  hour value, 0..31 accepted
- i_min  input  6  minute value, 0..63 accepted
- i_sec  input  6  second value, 0..63 accepted
- o_tx  output  1  UART serial out, idle high
- o_busy  output  1  high from request acceptance until the line completes
- o_done  output  1  one-clk pulse when the final stop bit ends

Behaviour:
- Reset (rst==0 at a clk edge) values: o_tx=1, o_busy=0, o_done=0, state=IDLE, byte index=0, tick and bit counters=0.
- Reset mid-frame aborts immediately. o_tx=1 on the next cycle; no partial byte or done pulse follows.
- Acceptance: i_send sampled high in IDLE. On that edge, i_hour, i_min and i_sec are captured into snapshot registers. o_busy=1 from the next cycle.
- i_send while busy is ignored, with no queueing. A held-high i_send retriggers a new line only after returning to IDLE (earliest the cycle after o_done).
- Input changes after acceptance do not affect the line in flight.
- Digit conversion from the snapshot: tens=v/10, ones=v%10, char=0x30+digit.
  - Every value 0..63 yields exactly two digits.
  - Out-of-clock-range values (e.g. hour 25, min 63) are sent as-is, with no saturation.
- Byte order:
  - With SEND_CRLF=1: Ht Ho ':' Mt Mo ':' St So 0x0D 0x0A.
  - With SEND_CRLF=0: the same sequence, stopping after So.
- Byte FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on acceptance. o_tx goes 0 the cycle after acceptance.
  - START: o_tx=0 for TICKS_PER_BIT b_ticks, then -> DATA with bit index 0.
  - DATA: o_tx=byte[bit]. Each bit lasts TICKS_PER_BIT b_ticks. After bit 7 -> STOP.
  - STOP: o_tx=1 for TICKS_PER_BIT b_ticks.
    - If bytes remain: increment byte index and go -> START with no idle gap.
    - If that was the last byte: -> IDLE, o_busy=0 and o_done=1 for exactly one cycle. Both take effect on the cycle after the b_tick that ends the final stop bit.
- Timing:
  - Each byte takes 10*TICKS_PER_BIT b_ticks (160 at default).
  - A line takes 1600 b_ticks with CRLF, 1280 without.
  - Cycles without b_tick hold all counters.
- The first start-bit duration counts from the first b_tick after acceptance. The start bit is therefore up to one tick period longer than nominal; this is acceptable.
- All outputs are registered; o_tx has no combinational path from the inputs.

Test Plan:
- Reset: hold rst=0 for 5 clk with i_send=1 -> o_tx=1, o_busy=0, o_done=0. After release, a line starts only once i_send is sampled in IDLE.
- Basic line: i_hour=12, i_min=34, i_sec=56, pulse i_send -> decoded bytes 0x31 0x32 0x3A 0x33 0x34 0x3A 0x35 0x36 0x0D 0x0A, each with start=0 and stop=1. o_busy high for 1600 b_ticks. Exactly one o_done pulse.
- Boundary values: 00:00:00 -> 0x30 0x30 0x3A 0x30 0x30 0x3A 0x30 0x30 0x0D 0x0A. Then 31:63:63 -> 0x33 0x31 0x3A 0x36 0x33 0x3A 0x36 0x33 0x0D 0x0A.
- Busy and snapshot: start 23:59:58, then pulse i_send and change inputs to 01:02:03 mid-line -> line still reads "23:59:58\r\n". No second line starts. o_done count = 1.
- Reset mid-frame: assert rst during byte 4, DATA bit 3 -> o_tx=1 next cycle and o_busy=0. No o_done. A fresh i_send afterwards sends a complete correct line.
- SEND_CRLF=0 with i_send held high: 07:08:09 -> 8 bytes "07:08:09", 1280 b_ticks. A new line begins the cycle after o_done. Back-to-back bytes have no idle gap between the stop and next start bit.
